// File: rtl/phy_mdio_sched.sv
// MDIO transaction scheduler: arbitrates host register accesses against a periodic
// link-status poll of every PHY, keeping exactly one MDIO transaction in flight.
module phy_mdio_sched #(
    parameter int NR_PHY      = 1,
    parameter int POLL_PERIOD = 100000,
    parameter int POLL_RA     = 1,
    parameter int LINK_BIT    = 2,
    parameter int TIMEOUT     = 4096,
    localparam int PW = (NR_PHY > 1) ? $clog2(NR_PHY) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] h_pa,
    input  logic [4:0]    h_ra,
    input  logic [15:0]   h_d,
    input  logic          h_rw,
    input  logic          h_req,
    output logic          h_ack,
    output logic [15:0]   h_rd_d,
    output logic          h_rd_dv,
    output logic [PW-1:0] m_mdio_pa,
    output logic [4:0]    m_mdio_ra,
    output logic [15:0]   m_mdio_d,
    output logic          m_mdio_rw,
    output logic          m_mdio_dv,
    input  logic          m_mdio_dr,
    input  logic [15:0]   s_mdio_d,
    input  logic          s_mdio_dv,
    output logic [NR_PHY-1:0] link_up,
    output logic          link_chg,
    output logic          timeout_err
);

    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int OW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PHY_LAST  = PW'(NR_PHY - 1);
    localparam logic [4:0]    POLL_RA5  = 5'(POLL_RA);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD
    } state_e;

    state_e            state_q,       state_d;
    logic [TW-1:0]     poll_cnt_q,    poll_cnt_d;
    logic              poll_pend_q,   poll_pend_d;
    logic [PW-1:0]     poll_idx_q,    poll_idx_d;
    logic [PW-1:0]     cmd_pa_q,      cmd_pa_d;
    logic [4:0]        cmd_ra_q,      cmd_ra_d;
    logic [15:0]       cmd_d_q,       cmd_d_d;
    logic              cmd_rw_q,      cmd_rw_d;
    logic              cmd_host_q,    cmd_host_d;
    logic              dv_q,          dv_d;
    logic [OW-1:0]     to_cnt_q,      to_cnt_d;
    logic [1:0]        wr_age_q,      wr_age_d;
    logic [NR_PHY-1:0] link_up_q,     link_up_d;
    logic              link_chg_q,    link_chg_d;
    logic [15:0]       h_rd_d_q,      h_rd_d_d;
    logic              h_rd_dv_q,     h_rd_dv_d;
    logic              timeout_err_q, timeout_err_d;

    logic poll_wrap;
    logic xact_ok;
    logic timed_out;
    logic pend_clr;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        poll_cnt_d    = poll_cnt_q;
        poll_pend_d   = poll_pend_q;
        poll_idx_d    = poll_idx_q;
        cmd_pa_d      = cmd_pa_q;
        cmd_ra_d      = cmd_ra_q;
        cmd_d_d       = cmd_d_q;
        cmd_rw_d      = cmd_rw_q;
        cmd_host_d    = cmd_host_q;
        dv_d          = 1'b0;
        to_cnt_d      = to_cnt_q;
        wr_age_d      = wr_age_q;
        link_up_d     = link_up_q;
        link_chg_d    = 1'b0;
        h_rd_d_d      = h_rd_d_q;
        h_rd_dv_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        h_ack         = 1'b0;
        xact_ok       = 1'b0;
        timed_out     = 1'b0;
        pend_clr      = 1'b0;

        poll_wrap  = (poll_cnt_q == POLL_LAST);
        poll_cnt_d = poll_wrap ? '0 : poll_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (h_req) begin
                    h_ack         = 1'b1;
                    cmd_pa_d      = h_pa;
                    cmd_ra_d      = h_ra;
                    cmd_d_d       = h_d;
                    cmd_rw_d      = h_rw;
                    cmd_host_d    = 1'b1;
                    timeout_err_d = 1'b0;
                    state_d       = ISSUE;
                end else if (poll_pend_q) begin
                    cmd_pa_d   = poll_idx_q;
                    cmd_ra_d   = POLL_RA5;
                    cmd_d_d    = '0;
                    cmd_rw_d   = 1'b0;
                    cmd_host_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (m_mdio_dr) begin
                    dv_d     = 1'b1;
                    wr_age_d = '0;
                    state_d  = cmd_rw_q ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_WR: begin
                // The master may still show ready right after the command; only trust
                // ready once it has had two cycles to drop.
                if (wr_age_q != 2'd2) begin
                    wr_age_d = wr_age_q + 1'b1;
                end
                if ((wr_age_q == 2'd2) && m_mdio_dr) begin
                    xact_ok = 1'b1;
                end
            end
            WAIT_RD: begin
                if (s_mdio_dv) begin
                    xact_ok = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (!xact_ok && (to_cnt_q == TO_LAST)) begin
                timed_out = 1'b1;
                dv_d      = 1'b0;
            end
        end

        if (xact_ok || timed_out) begin
            state_d = IDLE;
            if (cmd_host_q) begin
                if (!cmd_rw_q) begin
                    h_rd_dv_d = 1'b1;
                    h_rd_d_d  = timed_out ? 16'hFFFF : s_mdio_d;
                end
            end else begin
                if (xact_ok) begin
                    for (int i = 0; i < NR_PHY; i++) begin
                        if (cmd_pa_q == PW'(i)) begin
                            link_up_d[i] = s_mdio_d[LINK_BIT];
                        end
                    end
                    link_chg_d = (link_up_d != link_up_q);
                end
                if (poll_idx_q == PHY_LAST) begin
                    poll_idx_d = '0;
                    pend_clr   = 1'b1;
                end else begin
                    poll_idx_d = poll_idx_q + 1'b1;
                end
            end
            if (timed_out) begin
                timeout_err_d = 1'b1;
            end
        end

        // A wrap during an unfinished round is dropped rather than queued.
        if (poll_wrap && !poll_pend_q) begin
            poll_pend_d = 1'b1;
        end else if (pend_clr) begin
            poll_pend_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            poll_cnt_q    <= '0;
            poll_pend_q   <= 1'b0;
            poll_idx_q    <= '0;
            cmd_pa_q      <= '0;
            cmd_ra_q      <= '0;
            cmd_d_q       <= '0;
            cmd_rw_q      <= 1'b0;
            cmd_host_q    <= 1'b0;
            dv_q          <= 1'b0;
            to_cnt_q      <= '0;
            wr_age_q      <= '0;
            link_up_q     <= '0;
            link_chg_q    <= 1'b0;
            h_rd_d_q      <= '0;
            h_rd_dv_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            poll_cnt_q    <= poll_cnt_d;
            poll_pend_q   <= poll_pend_d;
            poll_idx_q    <= poll_idx_d;
            cmd_pa_q      <= cmd_pa_d;
            cmd_ra_q      <= cmd_ra_d;
            cmd_d_q       <= cmd_d_d;
            cmd_rw_q      <= cmd_rw_d;
            cmd_host_q    <= cmd_host_d;
            dv_q          <= dv_d;
            to_cnt_q      <= to_cnt_d;
            wr_age_q      <= wr_age_d;
            link_up_q     <= link_up_d;
            link_chg_q    <= link_chg_d;
            h_rd_d_q      <= h_rd_d_d;
            h_rd_dv_q     <= h_rd_dv_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign m_mdio_pa   = cmd_pa_q;
    assign m_mdio_ra   = cmd_ra_q;
    assign m_mdio_d    = cmd_d_q;
    assign m_mdio_rw   = cmd_rw_q;
    assign m_mdio_dv   = dv_q;
    assign h_rd_d      = h_rd_d_q;
    assign h_rd_dv     = h_rd_dv_q;
    assign link_up     = link_up_q;
    assign link_chg    = link_chg_q;
    assign timeout_err = timeout_err_q;

endmodule
